// File: rtl/led_breathe_pkg.sv
// Shared types and constants for the LED breathing sequencer.
// The phase codes appear directly on the phase output.
package led_breathe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } phase_t;

    localparam int unsigned PWM_BITS_DEFAULT = 8;

    function automatic int unsigned level_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    localparam int unsigned LEVEL_MAX = level_max(PWM_BITS_DEFAULT);

endpackage

// File: rtl/led_breathe_if.sv
// Run request, tick strobe and brightness outputs of the breathing sequencer.
// The sequencer is the slave; the tick source and the board logic form the master.
interface led_breathe_if #(
    parameter int unsigned PWM_BITS = 8
);
    logic                tick;
    logic                enable;
    logic                LED;
    logic [PWM_BITS-1:0] level;
    logic [2:0]          phase;

    modport master (
        output tick,
        output enable,
        input  LED,
        input  level,
        input  phase
    );

    modport slave (
        input  tick,
        input  enable,
        output LED,
        output level,
        output phase
    );
endinterface

// File: rtl/led_pwm.sv
// PWM core: free-running counter, duty register that reloads only at the period
// boundary, and a registered compare driving the pin.
module led_pwm
    import led_breathe_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [PWM_BITS-1:0] level,
    output logic                LED
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(level_max(PWM_BITS));

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    // Next-state: duty reloads on the last count so every period is whole.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        if (pwm_cnt_q == CNT_MAX) begin
            duty_d = level;
        end else begin
            duty_d = duty_q;
        end
        led_d = (pwm_cnt_q < duty_q);
    end

    // Counter, duty and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            led_q     <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: rtl/led_breathe.sv
// Breathing LED sequencer: ramps brightness up, holds, ramps down, holds,
// pacing each one-unit step by a fixed number of upstream ticks.
module led_breathe
    import led_breathe_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_TICKS = 4,
    parameter int unsigned HOLD_STEPS = 16
) (
    input  logic         clk,
    input  logic         resetn,
    led_breathe_if.slave bus
);

    localparam int unsigned TCW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int unsigned HCW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [TCW-1:0]      TICK_LAST = TCW'(STEP_TICKS - 1);
    localparam logic [HCW-1:0]      HOLD_LAST = HCW'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = PWM_BITS'(level_max(PWM_BITS));

    phase_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [TCW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [HCW-1:0]      hold_q, hold_d;
    logic                step_s;

    assign step_s = bus.tick && (tick_cnt_q == TICK_LAST);

    // Next-state logic; a dropped enable overrides any step event.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        tick_cnt_d = tick_cnt_q;
        hold_d     = hold_q;
        if ((state_q != ST_IDLE) && !bus.enable) begin
            state_d    = ST_IDLE;
            level_d    = '0;
            tick_cnt_d = '0;
            hold_d     = '0;
        end else begin
            if (bus.tick) begin
                tick_cnt_d = step_s ? '0 : (tick_cnt_q + TCW'(1));
            end else begin
                tick_cnt_d = tick_cnt_q;
            end
            case (state_q)
                ST_IDLE: begin
                    level_d    = '0;
                    tick_cnt_d = '0;
                    hold_d     = '0;
                    state_d    = bus.enable ? ST_UP : ST_IDLE;
                end
                ST_UP: begin
                    if (step_s && (level_q != LVL_MAX)) begin
                        level_d = level_q + PWM_BITS'(1);
                        if (level_q == (LVL_MAX - PWM_BITS'(1))) begin
                            state_d = ST_HOLD_HI;
                            hold_d  = '0;
                        end else begin
                            state_d = ST_UP;
                        end
                    end else begin
                        level_d = level_q;
                    end
                end
                ST_HOLD_HI: begin
                    if (step_s) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_DOWN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HCW'(1);
                        end
                    end else begin
                        hold_d = hold_q;
                    end
                end
                ST_DOWN: begin
                    if (step_s && (level_q != '0)) begin
                        level_d = level_q - PWM_BITS'(1);
                        if (level_q == PWM_BITS'(1)) begin
                            state_d = ST_HOLD_LO;
                            hold_d  = '0;
                        end else begin
                            state_d = ST_DOWN;
                        end
                    end else begin
                        level_d = level_q;
                    end
                end
                ST_HOLD_LO: begin
                    if (step_s) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_UP;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HCW'(1);
                        end
                    end else begin
                        hold_d = hold_q;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    level_d    = '0;
                    tick_cnt_d = '0;
                    hold_d     = '0;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            tick_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            tick_cnt_q <= tick_cnt_d;
            hold_q     <= hold_d;
        end
    end

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .resetn (resetn),
        .level  (level_q),
        .LED    (bus.LED)
    );

    assign bus.level = level_q;
    assign bus.phase = state_q;

endmodule

// File: tb/tb_led_breathe.sv
// Scoreboard bench for led_breathe with PWM_BITS=4, STEP_TICKS=2, HOLD_STEPS=3:
// a cycle model queues expected outputs, which are compared at the falling edge.
module tb_led_breathe;

    logic clk;
    logic resetn;

    led_breathe_if #(.PWM_BITS(4)) bus ();

    led_breathe #(
        .PWM_BITS   (4),
        .STEP_TICKS (2),
        .HOLD_STEPS (3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic       led;
        logic [3:0] level;
        logic [2:0] phase;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic en_lvl;

    int m_state, m_level, m_tc, m_hold, m_cnt, m_duty;
    logic m_led;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_level = 0; m_tc = 0; m_hold = 0;
        m_cnt = 0; m_duty = 0; m_led = 1'b0;
    endtask

    // Behavioural model of one rising edge, from the inputs about to be sampled.
    task automatic model_edge(input bit t, input bit en);
        int ns, nl, ntc, nh;
        bit step;
        if (!resetn) begin
            model_reset();
            return;
        end
        ns = m_state; nl = m_level; ntc = m_tc; nh = m_hold;
        step = t && (m_tc == 1);
        if (m_state != 0 && !en) begin
            ns = 0; nl = 0; ntc = 0; nh = 0;
        end else if (m_state == 0) begin
            nl = 0; ntc = 0; nh = 0;
            if (en) ns = 1;
        end else begin
            if (t) ntc = step ? 0 : m_tc + 1;
            if (step) begin
                case (m_state)
                    1: begin nl = m_level + 1; if (nl == 15) begin ns = 2; nh = 0; end end
                    2: begin if (m_hold == 2) begin ns = 3; nh = 0; end else nh = m_hold + 1; end
                    3: begin nl = m_level - 1; if (nl == 0) begin ns = 4; nh = 0; end end
                    4: begin if (m_hold == 2) begin ns = 1; nh = 0; end else nh = m_hold + 1; end
                    default: ns = 0;
                endcase
            end
        end
        m_led  = (m_cnt < m_duty);
        m_duty = (m_cnt == 15) ? m_level : m_duty;
        m_cnt  = (m_cnt + 1) % 16;
        m_state = ns; m_level = nl; m_tc = ntc; m_hold = nh;
    endtask

    task automatic cycle(input bit t);
        exp_t e;
        bus.tick   = t;
        bus.enable = en_lvl;
        model_edge(t, en_lvl);
        e.led   = m_led;
        e.level = 4'(m_level);
        e.phase = 3'(m_state);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq("led", {31'd0, bus.LED}, {31'd0, e.led});
        check_eq("level", {28'd0, bus.level}, {28'd0, e.level});
        check_eq("phase", {29'd0, bus.phase}, {29'd0, e.phase});
    endtask

    task automatic align();
        for (int i = 0; i < 16 && m_cnt != 0; i++) cycle(1'b0);
    endtask

    // One full PWM period, ticking during the first nticks cycles.
    task automatic measure(input int nticks, output int highs);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(i < nticks);
            highs += int'(bus.LED);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hi_len, lo_len, peak, highs;
        resetn = 1'b0;
        en_lvl = 1'b1;
        bus.tick = 1'b0;
        bus.enable = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset held with tick toggling.
        for (int i = 0; i < 8; i++) cycle(i[0]);
        check_eq("rst_phase", {29'd0, bus.phase}, 32'd0);

        // Full breathing cycle with a tick every clock.
        resetn = 1'b1;
        hi_len = 0; lo_len = 0; peak = 0;
        cycle(1'b1);
        for (int i = 0; i < 72; i++) begin
            cycle(1'b1);
            if (bus.phase == 3'd2) hi_len++;
            if (bus.phase == 3'd4) lo_len++;
            if (int'(bus.level) > peak) peak = int'(bus.level);
        end
        check_eq("hold_hi_len", hi_len, 32'd6);
        check_eq("hold_lo_len", lo_len, 32'd6);
        check_eq("peak_level", peak, 32'd15);
        check_eq("back_to_up", {29'd0, bus.phase}, 32'd1);

        // Enable drop coinciding with a step event at level 9.
        for (int i = 0; i < 19; i++) cycle(1'b1);
        check_eq("pre_drop_level", {28'd0, bus.level}, 32'd9);
        en_lvl = 1'b0;
        cycle(1'b1);
        check_eq("drop_phase", {29'd0, bus.phase}, 32'd0);
        check_eq("drop_level", {28'd0, bus.level}, 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0);
        align();
        measure(0, highs);
        check_eq("led_off_idle", highs, 32'd0);

        // Asynchronous reset mid-UP at level 7, taken while LED is high.
        en_lvl = 1'b1;
        cycle(1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b1);
        check_eq("pre_rst_level", {28'd0, bus.level}, 32'd7);
        for (int i = 0; i < 32 && !m_led; i++) cycle(1'b0);
        check_eq("pre_rst_led", {31'd0, bus.LED}, 32'd1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_eq("async_led", {31'd0, bus.LED}, 32'd0);
        check_eq("async_level", {28'd0, bus.level}, 32'd0);
        check_eq("async_phase", {29'd0, bus.phase}, 32'd0);
        @(negedge clk);
        cycle(1'b1);
        cycle(1'b0);
        resetn = 1'b1;

        // PWM duty at level 5, then a change to 12 in the middle of a period.
        cycle(1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0);
        align();
        measure(0, highs);
        check_eq("duty5", highs, 32'd5);
        measure(14, highs);
        check_eq("duty5_keep", highs, 32'd5);
        check_eq("level12", {28'd0, bus.level}, 32'd12);
        measure(0, highs);
        check_eq("duty12", highs, 32'd12);

        // Maximum level: one low cycle per period.
        for (int i = 0; i < 6; i++) cycle(1'b1);
        check_eq("hold_hi_phase", {29'd0, bus.phase}, 32'd2);
        for (int i = 0; i < 16; i++) cycle(1'b0);
        align();
        measure(0, highs);
        check_eq("duty15", highs, 32'd15);

        // Single ticks separated by long gaps.
        en_lvl = 1'b0;
        cycle(1'b0);
        en_lvl = 1'b1;
        cycle(1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1);
            check_eq("gap_level", {28'd0, bus.level}, 32'((k + 1) / 2));
            for (int i = 0; i < 1000; i++) cycle(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_breathe.md
# led_breathe

Downstream consumer of the board's free-running clock-divider stage: takes its one-cycle `tick` strobe and drives `LED` as a PWM output whose duty ramps up and down in a triangular "breathing" pattern. It replaces the plain square-wave blink with a brightness sequencer. A ramp/hold state machine sets the brightness level, and a PWM core converts that level to the pin.

## Interface
- `PWM_BITS`, 8: width of the PWM counter and the brightness level.
- `STEP_TICKS`, 4: `tick` pulses per one-unit brightness step; legal range ≥1.
- `HOLD_STEPS`, 16: step events spent at each extreme (max and 0) before reversing; legal range ≥1.
- `clk`  in  1  system clock; all logic rises on `posedge clk`.
- `resetn`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle strobe from the upstream divider; may be high on consecutive cycles.
- `enable`  in  1  level-sensitive run request.
- `LED`  out  1  registered PWM output.
- `level`  out  `PWM_BITS`  current brightness target.
- `phase`  out  3  current state encoding.

## Operation
- States: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4. Codes 5–7 are illegal and recover to IDLE on the next clock.
- Step event: `tick` high while `tick_cnt == STEP_TICKS-1`.
  - `tick_cnt` counts ticks modulo `STEP_TICKS`.
  - `tick_cnt` clears in IDLE.
- IDLE:
  - `level` = 0 and `tick_cnt` = 0.
  - `enable` = 1 moves to UP on the next edge.
- UP: each step event increments `level`. The step that makes `level` = 2^PWM_BITS−1 also moves to HOLD_HI. No wrap past max.
- HOLD_HI: counts `HOLD_STEPS` step events, then moves to DOWN.
- DOWN: each step event decrements `level`. The step that makes `level` = 0 also moves to HOLD_LO. No underflow.
- HOLD_LO: counts `HOLD_STEPS` step events, then moves to UP.
- `enable` = 0 in any non-IDLE state:
  - Moves to IDLE on the next edge.
  - Clears `level`, `tick_cnt` and the hold counter.
  - Takes priority over a simultaneous step event.
- PWM core:
  - `pwm_cnt` free-runs, +1 every clock, and wraps from 2^PWM_BITS−1 to 0.
  - `duty` loads from `level` only on the cycle `pwm_cnt` == 2^PWM_BITS−1. Duty therefore changes only at period boundaries; no partial periods.
  - `LED` is registered as (`pwm_cnt` < `duty`), unsigned compare.
  - `duty` = 0 → `LED` constantly 0. `duty` = max → `LED` high for 2^PWM_BITS−1 of every 2^PWM_BITS cycles.
- PWM is not gated by `enable`. In IDLE `level` = 0, so `LED` goes low within one PWM period.

## Timing
- Reset (async assert): `LED` = 0, `level` = 0, `phase` = IDLE. Also clears `pwm_cnt`, `duty`, `tick_cnt` and the hold counter.
- Reset deassertion is synchronised externally; release takes effect on the first `posedge clk` after `resetn` rises.
- Reset mid-ramp discards all progress. The sequence restarts from IDLE with `level` = 0.
- `tick` → `level` update: 1 cycle (registered on the step-event edge).
- `level` → `duty`: at the next PWM wrap, 1 to 2^PWM_BITS cycles later.
- `duty`/`pwm_cnt` → `LED`: 1 cycle (output register).
- Full cycle length: 2·(2^PWM_BITS−1)·`STEP_TICKS` + 2·`HOLD_STEPS`·`STEP_TICKS` ticks.

## Structure
- Package `led_breathe_pkg` holds:
  - the state enum (`phase_t`, 3 bits) and the five state codes;
  - localparam `LEVEL_MAX` (function of `PWM_BITS`).
- Sub-module `led_pwm`:
  - parameter `PWM_BITS`;
  - ports: `clk`, `resetn`, `level` in, `LED` out;
  - contains `pwm_cnt`, the `duty` latch and the compare/output register.
- The top level holds the state machine, `tick_cnt` and the hold counter.

## Test plan
All scenarios use `PWM_BITS`=4, `STEP_TICKS`=2, `HOLD_STEPS`=3 unless stated.
- Reset held, `tick` toggling → `LED`=0, `level`=0, `phase`=0 throughout. Assert `resetn` low mid-UP at `level`=7 → all outputs 0 immediately, before any clock edge.
- `enable`=1, `tick` every cycle →
  - `level` steps 0→15 every 2 ticks;
  - `phase` goes 1→2 on the step that reaches 15;
  - HOLD_HI lasts 6 ticks, then 3 (DOWN);
  - DOWN reaches 0, then 4 (HOLD_LO); after 6 ticks, back to 1.
- PWM duty: force `level`=5 and hold → `LED` high exactly 5 of every 16 cycles. Change `level` to 12 mid-period → the current period still shows 5 high cycles; the next shows 12.
- Extremes: `level`=0 → `LED` never high. `level`=15 → `LED` low exactly 1 cycle per 16.
- `enable` dropped on the same cycle as a step event in UP at `level`=9 → next edge `phase`=0 and `level`=0, not 10. `LED` is 0 by the end of the following PWM period.
- `tick` is only one cycle wide with gaps of 1000 clocks → `level` advances once per 2 ticks regardless of gap, with no missed or double steps.
